// File: rtl/dbg_uart_pkg.sv
// Shared types and constants for the debug UART transmitter.
package dbg_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int MODE_BIT  = 16;
  localparam int ENTRY_W   = 17;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  typedef logic [ENTRY_W-1:0] fifo_entry_t;

  // A queued entry carries the byte-mode flag above the 16-bit payload.
  function automatic fifo_entry_t pack_entry(input logic byte_mode, input logic [15:0] payload);
    return {byte_mode, payload};
  endfunction

endpackage

// File: rtl/dbg_uart_tx_if.sv
// Avalon-MM write-only link from the debug supervisor to the UART drain.
interface dbg_uart_tx_if;

  logic [15:0] av_address;
  logic [15:0] av_writedata;
  logic        av_write;
  logic        av_waitrequest;

  modport master (
    output av_address,
    output av_writedata,
    output av_write,
    input  av_waitrequest
  );

  modport slave (
    input  av_address,
    input  av_writedata,
    input  av_write,
    output av_waitrequest
  );

endinterface

// File: rtl/dbg_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
module dbg_fifo #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             sysclk,
  input  logic             sysreset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [LW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  // Storage array needs no reset; only pointers and flags define validity.
  always_ff @(posedge sysclk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered full/empty flags.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == LW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/dbg_uart_tx.sv
// Avalon-MM write slave that queues words and drains them as 8N1 UART frames.
module dbg_uart_tx
  import dbg_uart_pkg::*;
#(
  parameter  int DIVISOR    = 434,
  parameter  int FIFO_DEPTH = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              sysclk,
  input  logic              sysreset,
  dbg_uart_tx_if.slave      bus,
  output logic              uart_txd,
  output logic              tx_busy,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int                CNT_W     = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(DIVISOR - 1);
  localparam int                BIT_W     = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  tx_state_e         state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [7:0]        shreg;
  logic [7:0]        hi_byte;
  logic              hi_pending;
  fifo_entry_t       head;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              baud_last;
  logic              unused_addr;

  assign unused_addr        = ^bus.av_address[15:1];
  assign push               = bus.av_write && !bus.av_waitrequest;
  assign bus.av_waitrequest = fifo_full;
  assign pop                = (state == IDLE) && !fifo_empty;
  assign baud_last          = (baud_cnt == BAUD_LAST);
  assign tx_busy            = (state != IDLE) || !fifo_empty;

  dbg_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .push     (push),
    .wr_data  (pack_entry(bus.av_address[0], bus.av_writedata)),
    .pop      (pop),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Frame sequencer: baud timing, shift register and registered serial line.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      hi_byte    <= '0;
      hi_pending <= 1'b0;
      uart_txd   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!fifo_empty) begin
            shreg      <= head[7:0];
            hi_byte    <= head[15:8];
            hi_pending <= !head[MODE_BIT];
            uart_txd   <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_txd <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              uart_txd <= 1'b1;
              state    <= STOP;
            end else begin
              shreg    <= shreg >> 1;
              uart_txd <= shreg[1];
              bit_idx  <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (hi_pending) begin
              shreg      <= hi_byte;
              hi_pending <= 1'b0;
              uart_txd   <= 1'b0;
              state      <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_uart_tx.sv
// Self-checking bench for dbg_uart_tx: cycle model of queue and line, plus a UART receiver.
module tb_dbg_uart_tx;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic             sysclk = 1'b0;
  logic             sysreset = 1'b1;
  logic             uart_txd;
  logic             tx_busy;
  logic [LVL_W-1:0] fifo_level;

  dbg_uart_tx_if bus ();

  dbg_uart_tx #(
    .DIVISOR    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sysclk     (sysclk),
    .sysreset   (sysreset),
    .bus        (bus),
    .uart_txd   (uart_txd),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  // Model state: queued entries and the per-cycle line level still to be emitted.
  logic [16:0] mq[$];
  logic        wave[$];
  int          pops = 0;
  int          pre_size;
  logic [16:0] model_entry;

  // Receiver state and the bytes the bench expects to see on the line.
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_bytes[$];
  int          rx_cnt = -1;
  logic [7:0]  rx_sh = '0;

  logic        samp_txd  [0:127];
  logic        samp_busy [0:127];
  logic [LVL_W-1:0] samp_lvl [0:127];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void add_byte(input logic [7:0] b);
    for (int i = 0; i < DIV; i++) wave.push_back(1'b0);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < DIV; i++) wave.push_back(b[j]);
    for (int i = 0; i < DIV; i++) wave.push_back(1'b1);
  endfunction

  function automatic void push_expected(input logic mode, input logic [15:0] data);
    exp_bytes.push_back(data[7:0]);
    if (!mode) exp_bytes.push_back(data[15:8]);
  endfunction

  // Reference model: one idle cycle before each pop, then the whole frame is scheduled.
  always @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      mq.delete();
      wave.delete();
    end else begin
      pre_size = mq.size();
      if (wave.size() > 0) begin
        void'(wave.pop_front());
      end else if (mq.size() > 0) begin
        model_entry = mq.pop_front();
        add_byte(model_entry[7:0]);
        if (!model_entry[16]) add_byte(model_entry[15:8]);
        pops++;
      end
      if (bus.av_write === 1'b1 && pre_size < DEPTH)
        mq.push_back({bus.av_address[0], bus.av_writedata});
    end
  end

  // Every cycle, all outputs against the model.
  always @(negedge sysclk) begin
    checkOutput("txd", uart_txd, (wave.size() > 0) ? wave[0] : 1'b1);
    checkOutput("waitrequest", bus.av_waitrequest, mq.size() == DEPTH);
    checkOutput("fifo_level", fifo_level, mq.size());
    checkOutput("tx_busy", tx_busy, (wave.size() > 0) || (mq.size() > 0));
  end

  // Mid-bit sampling UART receiver collecting decoded bytes.
  always @(negedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      rx_cnt <= -1;
    end else if (rx_cnt < 0) begin
      if (uart_txd === 1'b0) rx_cnt <= 1;
    end else if (rx_cnt == 9 * DIV + DIV / 2) begin
      checkOutput("rx_stop_bit", uart_txd, 1);
      rx_q.push_back(rx_sh);
      rx_cnt <= -1;
    end else begin
      if (rx_cnt >= DIV + DIV / 2 && (rx_cnt % DIV) == DIV / 2)
        rx_sh <= {uart_txd, rx_sh[7:1]};
      rx_cnt <= rx_cnt + 1;
    end
  end

  task automatic applyStimulus(input logic mode, input logic [15:0] data, output int waited);
    logic [15:0] addr;
    addr = 16'($urandom);
    addr[0] = mode;
    @(negedge sysclk);
    bus.av_address   = addr;
    bus.av_writedata = data;
    bus.av_write     = 1'b1;
    waited = 0;
    while (bus.av_waitrequest === 1'b1 && waited < 500) begin
      @(negedge sysclk);
      waited++;
    end
    if (waited >= 500) begin
      checks++;
      errors++;
      $display("[TB] FAIL write_accept: waitrequest still high after %0d cycles", waited);
      bus.av_write = 1'b0;
    end else begin
      @(posedge sysclk);
      #1 bus.av_write = 1'b0;
      push_expected(mode, data);
    end
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge sysclk);
      samp_txd[k]  = uart_txd;
      samp_busy[k] = tx_busy;
      samp_lvl[k]  = fifo_level;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (tx_busy !== 1'b0 && n < 5000);
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: tx_busy still high after %0d cycles", n);
    end
    repeat (2) @(negedge sysclk);
  endtask

  task automatic checkRx();
    checkOutput("rx_byte_count", rx_q.size(), exp_bytes.size());
    for (int i = 0; i < rx_q.size() && i < exp_bytes.size(); i++)
      checkOutput("rx_byte", rx_q[i], exp_bytes[i]);
    rx_q.delete();
    exp_bytes.delete();
  endtask

  initial begin
    int          waited;
    int          n;
    int          base;
    logic [9:0]  exp_frame;
    logic [7:0]  dec;
    logic        mode;
    logic [15:0] data;

    bus.av_address   = '0;
    bus.av_writedata = '0;
    bus.av_write     = 1'b0;

    // Reset with the bus idle; outputs must stay at their rest values.
    #2 sysreset = 1'b0;
    repeat (3) @(negedge sysclk);
    checkOutput("reset_txd", uart_txd, 1);
    checkOutput("reset_waitrequest", bus.av_waitrequest, 0);
    checkOutput("reset_level", fifo_level, 0);
    checkOutput("reset_busy", tx_busy, 0);
    #1 sysreset = 1'b1;
    repeat (10) @(negedge sysclk);
    checkOutput("idle_hold_txd", uart_txd, 1);
    checkOutput("idle_hold_busy", tx_busy, 0);

    // Single byte 0x34: line 0,0,0,1,0,1,1,0,0,1, start two cycles after accept.
    applyStimulus(1'b1, 16'h1234, waited);
    capture(42);
    exp_frame = 10'b1001101000;
    checkOutput("s1_level_after_accept", samp_lvl[0], 1);
    checkOutput("s1_txd_before_start", samp_txd[0], 1);
    checkOutput("s1_level_after_pop", samp_lvl[1], 0);
    for (int b = 0; b < 10; b++)
      checkOutput($sformatf("s1_bit%0d", b),
                  {samp_txd[1+4*b], samp_txd[2+4*b], samp_txd[3+4*b], samp_txd[4+4*b]},
                  {4{exp_frame[b]}});
    checkOutput("s1_busy_last_stop", samp_busy[40], 1);
    checkOutput("s1_busy_after", samp_busy[41], 0);
    waitIdle();
    checkRx();

    // Word 0xA55A: bytes 5A then A5 back-to-back, 80 cycles total.
    applyStimulus(1'b0, 16'hA55A, waited);
    capture(82);
    for (int k = 0; k < 2; k++) begin
      dec = '0;
      for (int j = 0; j < 8; j++) dec[j] = samp_txd[1 + 40*k + 4*(j+1) + 2];
      checkOutput($sformatf("s2_byte%0d", k), dec, (k == 0) ? 8'h5A : 8'hA5);
      checkOutput($sformatf("s2_start%0d", k), samp_txd[1 + 40*k + 2], 0);
    end
    checkOutput("s2_no_gap", {samp_txd[40], samp_txd[41]}, 2'b10);
    checkOutput("s2_busy_last_stop", samp_busy[80], 1);
    checkOutput("s2_busy_after", samp_busy[81], 0);
    waitIdle();
    checkRx();

    // Six words back-to-back: queue fills after the fourth queued entry and the master holds.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 16'(16'h1100 * (i + 1) + i), waited);
      if (i == 4) begin
        checkOutput("s3_full_waitrequest", bus.av_waitrequest, 1);
        checkOutput("s3_full_level", fifo_level, 4);
      end
      if (i == 5) checkOutput("s3_master_held", waited > 0, 1);
    end
    waitIdle();
    checkRx();

    // Push and pop on the same edge at level 2.
    applyStimulus(1'b0, 16'hBEEF, waited);
    applyStimulus(1'b1, 16'h0011, waited);
    applyStimulus(1'b0, 16'h2233, waited);
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!(wave.size() == 0 && mq.size() == 2) && n < 1000);
    checkOutput("s4_level_before", fifo_level, 2);
    bus.av_address   = 16'h0000;
    bus.av_writedata = 16'h4455;
    bus.av_write     = 1'b1;
    @(posedge sysclk);
    #1 bus.av_write = 1'b0;
    push_expected(1'b0, 16'h4455);
    checkOutput("s4_level_after", fifo_level, 2);
    checkOutput("s4_txd_start", uart_txd, 0);
    waitIdle();
    checkRx();

    // Reset in the middle of the data bits of the second queued word.
    base = pops;
    applyStimulus(1'b0, 16'h1111, waited);
    applyStimulus(1'b0, 16'h0000, waited);
    applyStimulus(1'b1, 16'h0077, waited);
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!(pops == base + 2 && wave.size() == 60) && n < 2000);
    checkOutput("s5_txd_before_reset", uart_txd, 0);
    checkOutput("s5_level_before_reset", fifo_level, 1);
    #1 sysreset = 1'b0;
    #1;
    checkOutput("s5_txd_in_reset", uart_txd, 1);
    checkOutput("s5_level_in_reset", fifo_level, 0);
    checkOutput("s5_busy_in_reset", tx_busy, 0);
    rx_q.delete();
    exp_bytes.delete();
    repeat (3) @(negedge sysclk);
    #1 sysreset = 1'b1;
    applyStimulus(1'b1, 16'h00C3, waited);
    waitIdle();
    checkRx();

    // Randomised traffic: mixed modes, payloads and gaps.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(0, 90) : $urandom_range(0, 2)) @(negedge sysclk);
      mode = 1'($urandom_range(0, 1));
      data = 16'($urandom);
      applyStimulus(mode, data, waited);
    end
    waitIdle();
    checkRx();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
